// File: rtl/wb_sdram_arbiter.sv
// Two-master, one-slave Wishbone arbiter in front of wb_sdram.
// Whole bus cycles are granted round-robin and stay locked while the owner holds cyc.
// A watchdog aborts a stalled slave access and returns a one-cycle err to the owner.
//
// Handshake: a beat transfers when cyc & stb & ack are all high in the same
// cycle; the owning master keeps cyc/stb/adr/dat/sel stable until it sees ack
// (or err), and ack is only ever returned to the master that owns the bus.
module wb_sdram_arbiter #(
  parameter int ADR_W   = 24,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_cyc_i,
  input  logic               m0_stb_i,
  input  logic               m0_we_i,
  input  logic [ADR_W-1:0]   m0_adr_i,
  input  logic [DAT_W-1:0]   m0_dat_i,
  input  logic [DAT_W/8-1:0] m0_sel_i,
  output logic [DAT_W-1:0]   m0_dat_o,
  output logic               m0_ack_o,
  output logic               m0_err_o,
  input  logic               m1_cyc_i,
  input  logic               m1_stb_i,
  input  logic               m1_we_i,
  input  logic [ADR_W-1:0]   m1_adr_i,
  input  logic [DAT_W-1:0]   m1_dat_i,
  input  logic [DAT_W/8-1:0] m1_sel_i,
  output logic [DAT_W-1:0]   m1_dat_o,
  output logic               m1_ack_o,
  output logic               m1_err_o,
  output logic               s_cyc_o,
  output logic               s_stb_o,
  output logic               s_we_o,
  output logic [ADR_W-1:0]   s_adr_o,
  output logic [DAT_W-1:0]   s_dat_o,
  output logic [DAT_W/8-1:0] s_sel_o,
  input  logic [DAT_W-1:0]   s_dat_i,
  input  logic               s_ack_i,
  output logic [1:0]         grant_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;

  // Counter value at which the next stalled cycle trips the watchdog.
  localparam logic [TO_W-1:0] TO_HIT = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

  state_t          state;       // visible hierarchically for checkers
  logic            owner;       // 0 = m0, 1 = m1; kept through ABORT
  logic            last_owner;  // round-robin memory: loser of the next tie
  logic [TO_W-1:0] wdog;

  logic act0;
  logic act1;
  logic owner_cyc;

  // The mirror is gated by the owner's live cyc so s_cyc_o drops the same cycle.
  assign act0      = (state == OWN0) && m0_cyc_i;
  assign act1      = (state == OWN1) && m1_cyc_i;
  assign owner_cyc = owner ? m1_cyc_i : m0_cyc_i;
  assign busy_o    = (state != IDLE);

  // Route the owning master onto the slave port; everything else reads as zero.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (act0) begin
      s_cyc_o = 1'b1;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
    end else if (act1) begin
      s_cyc_o = 1'b1;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
    end
  end

  // Return path: ack only to the active owner, read data broadcast; both held
  // at zero while reset is asserted so nothing leaks out mid-reset.
  always_comb begin
    m0_ack_o = rst && act0 && m0_stb_i && s_ack_i;
    m1_ack_o = rst && act1 && m1_stb_i && s_ack_i;
    m0_dat_o = rst ? s_dat_i : '0;
    m1_dat_o = rst ? s_dat_i : '0;
  end

  // Arbitration FSM with watchdog, registered grant and registered err pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      wdog       <= '0;
      grant_o    <= 2'b00;
      m0_err_o   <= 1'b0;
      m1_err_o   <= 1'b0;
    end else begin
      m0_err_o <= 1'b0;
      m1_err_o <= 1'b0;
      case (state)
        IDLE: begin
          wdog <= '0;
          if (m0_cyc_i && (!m1_cyc_i || last_owner)) begin
            state   <= OWN0;
            owner   <= 1'b0;
            grant_o <= 2'b01;
          end else if (m1_cyc_i) begin
            state   <= OWN1;
            owner   <= 1'b1;
            grant_o <= 2'b10;
          end
        end
        OWN0, OWN1: begin
          if (!owner_cyc) begin
            state      <= IDLE;
            last_owner <= owner;
            grant_o    <= 2'b00;
            wdog       <= '0;
          end else if (!s_stb_o || s_ack_i || (TIMEOUT == 0)) begin
            // An ack on the tripping cycle wins over the timeout.
            wdog <= '0;
          end else if (wdog == TO_HIT) begin
            state <= ABORT;
            wdog  <= TO_MAX;
            if (owner) m1_err_o <= 1'b1;
            else       m0_err_o <= 1'b1;
          end else begin
            wdog <= wdog + TO_ONE;
          end
        end
        ABORT: begin
          wdog <= '0;
          if (!owner_cyc) begin
            state      <= IDLE;
            last_owner <= owner;
            grant_o    <= 2'b00;
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= 2'b00;
          wdog    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed bench for wb_sdram_arbiter (TIMEOUT = 8).
module tb_wb_sdram_arbiter;

  localparam int ADR_W = 24;
  localparam int DAT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             m0_cyc_i, m0_stb_i, m0_we_i;
  logic [ADR_W-1:0] m0_adr_i;
  logic [DAT_W-1:0] m0_dat_i;
  logic [3:0]       m0_sel_i;
  logic [DAT_W-1:0] m0_dat_o;
  logic             m0_ack_o, m0_err_o;
  logic             m1_cyc_i, m1_stb_i, m1_we_i;
  logic [ADR_W-1:0] m1_adr_i;
  logic [DAT_W-1:0] m1_dat_i;
  logic [3:0]       m1_sel_i;
  logic [DAT_W-1:0] m1_dat_o;
  logic             m1_ack_o, m1_err_o;
  logic             s_cyc_o, s_stb_o, s_we_o;
  logic [ADR_W-1:0] s_adr_o;
  logic [DAT_W-1:0] s_dat_o;
  logic [3:0]       s_sel_o;
  logic [DAT_W-1:0] s_dat_i;
  logic             s_ack_i;
  logic [1:0]       grant_o;
  logic             busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  wb_sdram_arbiter #(
    .ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(8), .TO_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
    s_dat_i = 32'hCAFE0000; s_ack_i = 0;

    // ---- reset state
    tick(); tick();
    check("rst_grant", grant_o, 2'b00);
    check("rst_cyc", s_cyc_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_m0_dat", m0_dat_o, 0);
    check("rst_m1_dat", m1_dat_o, 0);
    check("rst_adr", s_adr_o, 0);
    rst = 1'b1;
    tick();

    // ---- single m0 write, ack 3 cycles after grant
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1;
    m0_adr_i = 24'h000010; m0_dat_i = 32'hDEADBEEF; m0_sel_i = 4'hF;
    #1;
    check("t1_latency", s_cyc_o, 0);
    tick();
    check("t1_cyc", s_cyc_o, 1);
    check("t1_grant", grant_o, 2'b01);
    check("t1_adr", s_adr_o, 32'h10);
    check("t1_dat", s_dat_o, 32'hDEADBEEF);
    check("t1_sel", s_sel_o, 4'hF);
    check("t1_we", s_we_o, 1);
    check("t1_busy", busy_o, 1);
    check("t1_noack", m0_ack_o, 0);
    tick(); tick();
    s_ack_i = 1;
    #1;
    check("t1_ack", m0_ack_o, 1);
    check("t1_m1_ack", m1_ack_o, 0);
    tick();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    #1;
    check("t1_ack_once", m0_ack_o, 0);
    check("t1_cyc_drop", s_cyc_o, 0);
    tick();
    check("t1_idle_grant", grant_o, 2'b00);
    check("t1_idle_busy", busy_o, 0);

    // ---- tie from reset: m0 first, one idle cycle, then m1
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 24'h000100;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 24'h000200;
    tick();
    check("t2_grant_m0", grant_o, 2'b01);
    check("t2_adr_m0", s_adr_o, 32'h100);
    s_ack_i = 1;
    #1;
    check("t2_m0_ack", m0_ack_o, 1);
    check("t2_m1_held", m1_ack_o, 0);
    tick();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    check("t2_gap_grant", grant_o, 2'b00);
    check("t2_gap_cyc", s_cyc_o, 0);
    tick();
    check("t2_grant_m1", grant_o, 2'b10);
    check("t2_adr_m1", s_adr_o, 32'h200);

    // ---- m1 holds for 4 read beats while m0 waits
    m1_we_i = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 24'h000300;
    for (int i = 1; i <= 4; i++) begin
      s_dat_i = i; s_ack_i = 1;
      #1;
      check("t3_m1_ack", m1_ack_o, 1);
      check("t3_m1_dat", m1_dat_o, i);
      check("t3_m0_wait", m0_ack_o, 0);
      check("t3_grant", grant_o, 2'b10);
      tick();
    end
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    tick();
    check("t3_gap_grant", grant_o, 2'b00);
    tick();
    check("t3_grant_m0", grant_o, 2'b01);
    m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    check("t3_idle", busy_o, 0);

    // ---- watchdog: m0 read never acked, m1 pending behind it
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 24'h000400;
    tick();
    check("t4_grant", grant_o, 2'b01);
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 24'h000500;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("t4_no_err_yet", m0_err_o, 0);
    end
    tick();
    check("t4_err", m0_err_o, 1);
    check("t4_m1_err", m1_err_o, 0);
    check("t4_abort_cyc", s_cyc_o, 0);
    check("t4_abort_grant", grant_o, 2'b01);
    check("t4_abort_busy", busy_o, 1);
    tick();
    check("t4_err_once", m0_err_o, 0);
    check("t4_abort_hold", s_cyc_o, 0);
    check("t4_abort_hold_busy", busy_o, 1);
    s_ack_i = 1;
    #1;
    check("t4_late_ack", m0_ack_o, 0);
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    check("t4_idle_grant", grant_o, 2'b00);
    tick();
    check("t4_grant_m1", grant_o, 2'b10);
    check("t4_adr_m1", s_adr_o, 32'h500);

    // ---- reset in the middle of an m1 transfer
    check("t5_cyc_before", s_cyc_o, 1);
    rst = 1'b0; s_ack_i = 1;
    #1;
    check("t5_rst_ack", m1_ack_o, 0);
    check("t5_rst_dat", m1_dat_o, 0);
    tick();
    check("t5_cyc", s_cyc_o, 0);
    check("t5_grant", grant_o, 2'b00);
    check("t5_busy", busy_o, 0);
    check("t5_ack", m1_ack_o, 0);
    rst = 1'b1; s_ack_i = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 24'h000600;
    tick();
    check("t5_tie_m0", grant_o, 2'b01);
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    tick();
    tick();

    // ---- ack on the tripping cycle wins; counter restarts
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 24'h000700;
    tick();
    for (int k = 1; k <= 7; k++) tick();
    s_ack_i = 1;
    #1;
    check("t6_ack", m0_ack_o, 1);
    tick();
    s_ack_i = 0;
    check("t6_no_err", m0_err_o, 0);
    check("t6_still_own", grant_o, 2'b01);
    check("t6_still_cyc", s_cyc_o, 1);
    for (int k = 1; k <= 7; k++) tick();
    check("t6_restart_no_err", m0_err_o, 0);
    s_ack_i = 1;
    tick();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    check("t6_done_err", m0_err_o, 0);
    tick();
    check("t6_idle", grant_o, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_sdram_arbiter.md
Name: wb_sdram_arbiter

Overview:
Two-master, one-slave Wishbone arbiter that shares the wb_sdram controller between the FSMC bridge (master 0) and a second bus master such as a DMA or capture engine (master 1). It grants whole bus cycles (cyc-locked) using round-robin priority. A per-transaction watchdog aborts a stalled slave access and returns an error to the owning master.

Parameters:
ADR_W, 24, master/slave address width
DAT_W, 32, data width (SEL width = DAT_W/8)
TIMEOUT, 255, max cycles stb may wait for ack before abort; 0 disables the watchdog
TO_W, 8, watchdog counter width; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls
m0_adr_i  in  ADR_W  master 0 address
m0_dat_i  in  DAT_W  master 0 write data
m0_sel_i  in  DAT_W/8  master 0 byte selects
m0_dat_o  out  DAT_W  read data to master 0
m0_ack_o, m0_err_o  out  1 each  master 0 ack / error
m1_*  same set as m0_*  master 1
s_cyc_o, s_stb_o, s_we_o  out  1 each  to wb_sdram
s_adr_o  out  ADR_W; s_dat_o  out  DAT_W; s_sel_o  out  DAT_W/8
s_dat_i  in  DAT_W; s_ack_i  in  1  from wb_sdram
grant_o  out  2  one-hot current owner (bit0 = m0, bit1 = m1); 00 when idle
busy_o  out  1  state != IDLE

Behaviour:
- States: IDLE, OWN0, OWN1, ABORT. The owner register holds 0/1 in ABORT.
- Reset (rst == 0 at a clk edge): state IDLE, last_owner = 1 (m0 wins the first tie), watchdog = 0, and every output is 0 (grant_o = 00, s_cyc_o/s_stb_o/s_we_o = 0, s_adr_o/s_dat_o/s_sel_o = 0, m*_ack_o/m*_err_o = 0, m*_dat_o = 0 while reset is asserted). Reset mid-transaction drops s_cyc_o on the next edge; no ack or err is issued.
- IDLE:
  - Exactly one mN_cyc_i high: go to OWNn.
  - Both high: grant the master != last_owner.
  - Neither high: stay in IDLE.
  - Grant latency is 1 cycle: cyc seen at edge N, s_cyc_o high in the cycle after edge N.
- OWNn:
  - s_cyc_o = 1; s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o mirror master n combinationally.
  - mn_ack_o = s_ack_i & mn_stb_i.
  - Other master sees ack = 0 and err = 0 and is held off.
  - The grant is held across multiple stb/ack beats while mn_cyc_i stays high. No preemption.
  - mn_cyc_i low: go to IDLE, set last_owner = n, drop s_cyc_o the same cycle (combinational mirror gated by cyc). At least one IDLE cycle separates owners.
- Not owning: slave control outputs are 0; address/data/sel are 0.
- Read data: m0_dat_o = m1_dat_o = s_dat_i (unconditional broadcast; valid only with ack).
- Watchdog:
  - Clears to 0 on any cycle with s_ack_i = 1, with stb low, or outside OWNn.
  - Increments each OWNn cycle with s_stb_o = 1 and s_ack_i = 0.
  - When it equals TIMEOUT (TIMEOUT != 0): registered one-cycle mn_err_o pulse, go to ABORT.
- ABORT:
  - s_cyc_o = s_stb_o = 0; ack/err = 0.
  - Stay until the owner's cyc is low, then go to IDLE with last_owner = owner.
- Simultaneous ack and timeout edge: ack wins; counter clears, no err.
- Late s_ack_i arriving in ABORT/IDLE is ignored (not forwarded).
- The watchdog counter saturates at TIMEOUT, with no wrap.
- grant_o is the registered one-hot owner, valid in OWNn and ABORT.

Test Plan:
- Single m0 write (adr 0x000010, dat 0xDEADBEEF, sel 0xF), slave acks 3 cycles later -> s_cyc_o rises 1 cycle after m0_cyc_i, s_adr_o/s_dat_o match, m0_ack_o pulses once, grant_o = 01, m1_ack_o stays 0.
- m0 and m1 raise cyc in the same cycle from reset -> m0 granted first; after m0 drops cyc, one IDLE cycle, then m1 granted (grant_o 01 -> 00 -> 10).
- m1 holds cyc for 4 stb/ack read beats (s_dat_i = 0x1..0x4) while m0 requests -> m0 waits; m1_dat_o returns 1, 2, 3, 4 with 4 acks; m0 is granted only after m1 drops cyc.
- TIMEOUT = 8, slave never acks m0 read -> m0_err_o pulses exactly once, 8 cycles after stb; s_cyc_o drops; stays ABORT until m0_cyc_i low; a pending m1 is then granted.
- rst low for one cycle during an m1 transfer -> next cycle all outputs 0, state IDLE; a subsequent tie grants m0.
- Slave acks in the cycle the counter would reach TIMEOUT -> ack delivered, no err, transfer completes normally.
